// File: rtl/counter_checker_if.sv
// Observation interface between a counter's sampled output and counter_checker.
// The master side drives samples and clear; the slave (the checker) returns status.
interface counter_checker_if #(
    parameter int WIDTH     = 4,
    parameter int ERR_WIDTH = 8
);
    logic                 i_valid;
    logic [WIDTH-1:0]     i_value;
    logic                 i_clear;
    logic                 o_locked;
    logic                 o_err;
    logic                 o_restart;
    logic [ERR_WIDTH-1:0] o_err_count;
    logic [WIDTH-1:0]     o_expected;

    modport master (
        output i_valid, i_value, i_clear,
        input  o_locked, o_err, o_restart, o_err_count, o_expected
    );

    modport slave (
        input  i_valid, i_value, i_clear,
        output o_locked, o_err, o_restart, o_err_count, o_expected
    );
endinterface

// File: rtl/counter_checker.sv
// Sequence checker: verifies each valid sample is the previous one plus one (mod 2^WIDTH),
// locks onto a running sequence and keeps a saturating discontinuity count.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | no sample seen since reset; next valid sample seeds the reference
// S_ACQUIRE | counting consecutive correct increments toward LOCK_COUNT
// S_LOCKED  | locked; discontinuities are reported as errors or restarts
module counter_checker #(
    parameter int WIDTH         = 4,
    parameter int LOCK_COUNT    = 3,
    parameter int ERR_WIDTH     = 8,
    parameter int ALLOW_RESTART = 1
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    counter_checker_if.slave   chk
);
    localparam int STREAK_W = $clog2(LOCK_COUNT + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ACQUIRE = 2'd1;
    localparam logic [1:0] S_LOCKED  = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [WIDTH-1:0]     expected_q, expected_d;
    logic [STREAK_W-1:0]  streak_q, streak_d;
    logic [ERR_WIDTH-1:0] err_count_q, err_count_d;
    logic                 err_q, err_d;
    logic                 restart_q, restart_d;
    logic                 correct;

    // expected_q holds the last accepted sample + 1, so the wrap from max to 0 falls out of the WIDTH-bit add.
    assign correct = (chk.i_value == expected_q);

    always_comb begin
        state_d     = state_q;
        expected_d  = expected_q;
        streak_d    = streak_q;
        err_count_d = err_count_q;
        err_d       = 1'b0;
        restart_d   = 1'b0;

        if (chk.i_valid) begin
            expected_d = chk.i_value + 1'b1;
            case (state_q)
                S_IDLE: begin
                    state_d  = S_ACQUIRE;
                    streak_d = '0;
                end
                S_ACQUIRE: begin
                    if (correct) begin
                        streak_d = streak_q + 1'b1;
                        if (streak_q == STREAK_W'(LOCK_COUNT - 1)) begin
                            state_d = S_LOCKED;
                        end
                    end else begin
                        streak_d = '0;
                    end
                end
                S_LOCKED: begin
                    if (!correct) begin
                        if ((ALLOW_RESTART != 0) && (chk.i_value == '0)) begin
                            restart_d = 1'b1;
                        end else begin
                            err_d    = 1'b1;
                            streak_d = '0;
                            state_d  = S_ACQUIRE;
                            if (err_count_q != '1) begin
                                err_count_d = err_count_q + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_d  = S_IDLE;
                    streak_d = '0;
                end
            endcase
        end

        // Clear overrides a coinciding error but leaves the lock FSM alone.
        if (chk.i_clear) begin
            err_count_d = '0;
            err_d       = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= S_IDLE;
            expected_q  <= WIDTH'(1);
            streak_q    <= '0;
            err_count_q <= '0;
            err_q       <= 1'b0;
            restart_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            streak_q    <= streak_d;
            err_count_q <= err_count_d;
            err_q       <= err_d;
            restart_q   <= restart_d;
        end
    end

    assign chk.o_locked    = (state_q == S_LOCKED);
    assign chk.o_err       = err_q;
    assign chk.o_restart   = restart_q;
    assign chk.o_err_count = err_count_q;
    assign chk.o_expected  = expected_q;
endmodule

// File: tb/tb_counter_checker.sv
// Bench for counter_checker: three instances (default, no-restart, 2-bit error count)
// driven with the same directed sample stream and checked against a scoreboard model.
module tb_counter_checker;
    typedef struct packed {
        logic       locked;
        logic       err;
        logic       restart;
        logic [7:0] cnt;
        logic [3:0] nxt;
    } obs_t;

    localparam obs_t RESET_OBS = '{locked: 1'b0, err: 1'b0, restart: 1'b0, cnt: 8'd0, nxt: 4'd1};

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    counter_checker_if #(.WIDTH(4), .ERR_WIDTH(8)) if_a ();
    counter_checker_if #(.WIDTH(4), .ERR_WIDTH(8)) if_b ();
    counter_checker_if #(.WIDTH(4), .ERR_WIDTH(2)) if_c ();

    counter_checker #(.WIDTH(4), .LOCK_COUNT(3), .ERR_WIDTH(8), .ALLOW_RESTART(1)) dut_a (
        .i_clk(clk), .i_reset_n(rst_n), .chk(if_a));
    counter_checker #(.WIDTH(4), .LOCK_COUNT(3), .ERR_WIDTH(8), .ALLOW_RESTART(0)) dut_b (
        .i_clk(clk), .i_reset_n(rst_n), .chk(if_b));
    counter_checker #(.WIDTH(4), .LOCK_COUNT(3), .ERR_WIDTH(2), .ALLOW_RESTART(1)) dut_c (
        .i_clk(clk), .i_reset_n(rst_n), .chk(if_c));

    int checks = 0;
    int errors = 0;
    int step_no = 0;
    string scen = "init";

    // Reference model state per instance: 0 idle, 1 acquire, 2 locked
    int         m_st[3];
    int         m_streak[3];
    int         m_cnt[3];
    logic [3:0] m_nxt[3];
    int         m_max[3]   = '{255, 255, 3};
    bit         m_allow[3] = '{1'b1, 1'b0, 1'b1};
    obs_t       sb[$];

    function automatic obs_t sample(int k);
        obs_t o;
        case (k)
            0:       o = obs_t'({if_a.o_locked, if_a.o_err, if_a.o_restart, if_a.o_err_count, if_a.o_expected});
            1:       o = obs_t'({if_b.o_locked, if_b.o_err, if_b.o_restart, if_b.o_err_count, if_b.o_expected});
            default: o = obs_t'({if_c.o_locked, if_c.o_err, if_c.o_restart, 6'd0, if_c.o_err_count, if_c.o_expected});
        endcase
        return o;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            m_st[k] = 0; m_streak[k] = 0; m_cnt[k] = 0; m_nxt[k] = 4'd1;
        end
        sb.delete();
    endfunction

    function automatic void model_update(int k, logic v, logic [3:0] val, logic clr);
        logic e, r, ok;
        obs_t o;
        e = 1'b0; r = 1'b0;
        if (v) begin
            ok = (val == m_nxt[k]);
            if (m_st[k] == 0) begin
                m_st[k] = 1; m_streak[k] = 0;
            end else if (m_st[k] == 1) begin
                if (ok) begin
                    m_streak[k]++;
                    if (m_streak[k] >= 3) m_st[k] = 2;
                end else begin
                    m_streak[k] = 0;
                end
            end else if (!ok) begin
                if (m_allow[k] && val == 4'd0) begin
                    r = 1'b1;
                end else begin
                    e = 1'b1;
                    if (m_cnt[k] < m_max[k]) m_cnt[k]++;
                    m_streak[k] = 0;
                    m_st[k] = 1;
                end
            end
            m_nxt[k] = val + 4'd1;
        end
        if (clr) begin
            m_cnt[k] = 0; e = 1'b0;
        end
        o.locked = (m_st[k] == 2); o.err = e; o.restart = r;
        o.cnt = 8'(m_cnt[k]); o.nxt = m_nxt[k];
        sb.push_back(o);
    endfunction

    task automatic check(input string tag, input logic [14:0] obs, input logic [14:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] val, input logic clr);
        if_a.i_valid = v; if_a.i_value = val; if_a.i_clear = clr;
        if_b.i_valid = v; if_b.i_value = val; if_b.i_clear = clr;
        if_c.i_valid = v; if_c.i_value = val; if_c.i_clear = clr;
    endtask

    task automatic step(input logic v, input logic [3:0] val, input logic clr);
        obs_t exp;
        drive(v, val, clr);
        for (int k = 0; k < 3; k++) model_update(k, v, val, clr);
        @(posedge clk);
        #1;
        step_no++;
        for (int k = 0; k < 3; k++) begin
            if (sb.size() == 0) begin
                check($sformatf("%s sb_empty dut%0d", scen, k), 15'd1, 15'd0);
            end else begin
                exp = sb.pop_front();
                check($sformatf("%s dut%0d step%0d", scen, k, step_no), sample(k), exp);
            end
        end
    endtask

    // Asserts reset between clock edges and checks every instance clears before the next edge.
    task automatic reset_seq();
        drive(1'b0, 4'd0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 3; k++) check($sformatf("%s reset dut%0d", scen, k), sample(k), RESET_OBS);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic lock_from(input logic [3:0] start);
        for (int i = 0; i < 4; i++) step(1'b1, start + 4'(i), 1'b0);
    endtask

    initial begin
        int pulses;
        logic [3:0] v;
        drive(1'b0, 4'd0, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        scen = "por";
        reset_seq();

        scen = "freerun";
        for (int i = 0; i < 18; i++) begin
            step(1'b1, 4'(i), 1'b0);
            if (i == 2) check("freerun locked_after_3rd", 15'(if_a.o_locked), 15'd0);
            if (i == 3) check("freerun locked_after_4th", 15'(if_a.o_locked), 15'd1);
        end
        check("freerun locked_after_wrap", 15'(if_a.o_locked), 15'd1);
        check("freerun err_count", 15'(if_a.o_err_count), 15'd0);

        scen = "skip";
        reset_seq();
        lock_from(4'd5);
        step(1'b1, 4'd10, 1'b0);
        check("skip err_pulse", 15'(if_a.o_err), 15'd1);
        check("skip locked_drop", 15'(if_a.o_locked), 15'd0);
        step(1'b1, 4'd11, 1'b0);
        check("skip err_single", 15'(if_a.o_err), 15'd0);
        step(1'b1, 4'd12, 1'b0);
        step(1'b1, 4'd13, 1'b0);
        check("skip relock", 15'(if_a.o_locked), 15'd1);
        check("skip err_count", 15'(if_a.o_err_count), 15'd1);

        scen = "restart";
        reset_seq();
        lock_from(4'd2);
        step(1'b1, 4'd6, 1'b0);
        step(1'b1, 4'd0, 1'b0);
        check("restart pulse_a", 15'(if_a.o_restart), 15'd1);
        check("restart locked_a", 15'(if_a.o_locked), 15'd1);
        check("restart err_b", 15'(if_b.o_err), 15'd1);
        check("restart count_b", 15'(if_b.o_err_count), 15'd1);
        step(1'b1, 4'd1, 1'b0);
        check("restart count_a", 15'(if_a.o_err_count), 15'd0);
        check("restart pulse_once", 15'(if_a.o_restart), 15'd0);

        scen = "gapped";
        reset_seq();
        lock_from(4'd0);
        for (int i = 4; i < 9; i++) begin
            step(1'b1, 4'(i), 1'b0);
            step(1'b0, 4'($urandom_range(15)), 1'b0);
        end
        check("gapped no_err", 15'(if_a.o_err_count), 15'd0);
        step(1'b1, 4'd12, 1'b0);
        check("gapped count_before_clear", 15'(if_a.o_err_count), 15'd1);
        lock_from(4'd13);
        step(1'b1, 4'd3, 1'b1);
        check("gapped clear_err", 15'(if_a.o_err), 15'd0);
        check("gapped clear_count", 15'(if_a.o_err_count), 15'd0);
        check("gapped clear_unlock", 15'(if_a.o_locked), 15'd0);

        scen = "saturate";
        reset_seq();
        lock_from(4'd0);
        v = 4'd3;
        pulses = 0;
        for (int n = 0; n < 5; n++) begin
            v = v + 4'd2;
            step(1'b1, v, 1'b0);
            pulses += int'(if_c.o_err);
            for (int j = 0; j < 3; j++) begin
                v = v + 4'd1;
                step(1'b1, v, 1'b0);
                pulses += int'(if_c.o_err);
            end
        end
        check("saturate pulses_c", 15'(pulses), 15'd5);
        check("saturate count_c", 15'(if_c.o_err_count), 15'd3);
        check("saturate count_a", 15'(if_a.o_err_count), 15'd5);

        scen = "asyncrst";
        reset_seq();
        lock_from(4'd0);
        step(1'b1, 4'd6, 1'b0);
        lock_from(4'd6);
        step(1'b1, 4'd12, 1'b0);
        lock_from(4'd12);
        check("asyncrst pre_count", 15'(if_a.o_err_count), 15'd2);
        check("asyncrst pre_locked", 15'(if_a.o_locked), 15'd1);
        reset_seq();
        step(1'b1, 4'd7, 1'b0);
        check("asyncrst first_sample_exp", 15'(if_a.o_expected), 15'd8);
        step(1'b1, 4'd8, 1'b0);
        step(1'b1, 4'd9, 1'b0);
        step(1'b1, 4'd10, 1'b0);
        check("asyncrst relock", 15'(if_a.o_locked), 15'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
